// File: rtl/ctrl_seq_v2.sv
// ctrl_seq_v2: Moore-FSM instruction controller. It fetches 16-bit instructions from a
//   synchronous ROM into the IR and decodes them into datapath control.
// Latency: ROM_LAT+2 cycles per instruction, LOAD takes ROM_LAT+3, HALT is terminal.
//   Control outputs are combinational from the state and the IR.
// Backpressure: none. The ROM is assumed to return data within ROM_LAT cycles, and
//   the datapath always accepts the controls.
// Ports: Clk/Reset (async active-low); rom_addr/rom_q connect the instruction ROM;
//   alu_zero is the datapath zero flag; PC_Out/IR_Out expose the PC and the IR;
//   D_* control data memory; RF_* control the register file; ALU_s0 selects the
//   ALU operation; outState/nextState show the FSM; illegal is a sticky bad-opcode flag.
// Optional feature: define CTRL_JZ_EN to build the jump-if-zero (opcode 7) path.
module ctrl_seq_v2 #(
  parameter int PC_W      = 7,
  parameter int ROM_LAT   = 1,
  parameter int RESET_VEC = 0
) (
  input  logic            Clk,
  input  logic            Reset,
  output logic [PC_W-1:0] rom_addr,
  input  logic [15:0]     rom_q,
  input  logic            alu_zero,
  output logic [PC_W-1:0] PC_Out,
  output logic [15:0]     IR_Out,
  output logic [7:0]      D_Addr,
  output logic            D_Wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_Addr,
  output logic [3:0]      RF_Ra_Addr,
  output logic [3:0]      RF_Rb_Addr,
  output logic            RF_W_en,
  output logic [2:0]      ALU_s0,
  output logic [3:0]      outState,
  output logic [3:0]      nextState,
  output logic            illegal
);

  typedef enum logic [3:0] {
    S_INIT   = 4'h0,
    S_FETCH  = 4'h1,
    S_DECODE = 4'h2,
    S_NOOP   = 4'h3,
    S_LOADA  = 4'h4,
    S_LOADB  = 4'h5,
    S_STORE  = 4'h6,
    S_ADD    = 4'h7,
    S_HALT   = 4'h8,
    S_SUB    = 4'h9,
    S_JMP    = 4'hA,
    S_JZ     = 4'hB
  } state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic [1:0]      fcnt;
  logic            last_fetch;
  logic            illegal_set;
  logic [3:0]      opcode;

  assign opcode     = ir[15:12];
  // The final Fetch cycle is the one in which rom_q holds the data for the current PC.
  assign last_fetch = (fcnt == 2'(ROM_LAT - 1));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= S_INIT;
      pc      <= PC_W'(RESET_VEC);
      ir      <= 16'h0000;
      fcnt    <= 2'd0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) begin
        fcnt <= last_fetch ? 2'd0 : fcnt + 2'd1;
      end else begin
        fcnt <= 2'd0;
      end
      if (state == S_FETCH && last_fetch) begin
        ir <= rom_q;
        pc <= pc + PC_W'(1);
      end
      // The jump target replaces the PC that was already incremented during Fetch.
      if (state == S_JMP) begin
        pc <= ir[PC_W-1:0];
      end
`ifdef CTRL_JZ_EN
      if (state == S_JZ && alu_zero) begin
        pc <= ir[PC_W-1:0];
      end
`endif
      if (illegal_set) begin
        illegal <= 1'b1;
      end
    end
  end

`ifndef CTRL_JZ_EN
  // alu_zero has no function in this build.
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;
`endif

  always_comb begin
    state_nxt   = state;
    illegal_set = 1'b0;
    case (state)
      S_INIT:   state_nxt = S_FETCH;
      S_FETCH:  if (last_fetch) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          4'h0:    state_nxt = S_NOOP;
          4'h1:    state_nxt = S_STORE;
          4'h2:    state_nxt = S_LOADA;
          4'h3:    state_nxt = S_ADD;
          4'h4:    state_nxt = S_SUB;
          4'h5:    state_nxt = S_HALT;
          4'h6:    state_nxt = S_JMP;
`ifdef CTRL_JZ_EN
          4'h7:    state_nxt = S_JZ;
`endif
          default: begin
            state_nxt   = S_NOOP;
            illegal_set = 1'b1;
          end
        endcase
      end
      S_LOADA:  state_nxt = S_LOADB;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    D_Addr     = 8'h00;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_Addr  = 4'h0;
    RF_Ra_Addr = 4'h0;
    RF_Rb_Addr = 4'h0;
    RF_W_en    = 1'b0;
    ALU_s0     = 3'b000;
    case (state)
      S_STORE: begin
        D_Addr     = ir[11:4];
        RF_Ra_Addr = ir[3:0];
        D_Wr       = 1'b1;
      end
      S_LOADA: begin
        D_Addr    = ir[11:4];
        RF_W_Addr = ir[3:0];
        RF_s      = 1'b1;
      end
      S_LOADB: begin
        D_Addr    = ir[11:4];
        RF_W_Addr = ir[3:0];
        RF_s      = 1'b1;
        RF_W_en   = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_Addr = ir[11:8];
        RF_Rb_Addr = ir[7:4];
        RF_W_Addr  = ir[3:0];
        ALU_s0     = (state == S_ADD) ? 3'b001 : 3'b010;
        RF_W_en    = 1'b1;
      end
`ifdef CTRL_JZ_EN
      S_JZ: begin
        RF_Ra_Addr = ir[11:8];
        ALU_s0     = 3'b000;
      end
`endif
      default: ;
    endcase
  end

  assign rom_addr  = pc;
  assign PC_Out    = pc;
  assign IR_Out    = ir;
  assign outState  = state;
  assign nextState = state_nxt;

endmodule

// File: tb/tb_ctrl_seq_v2.sv
// tb_ctrl_seq_v2: directed bench for ctrl_seq_v2.
// Instance A has PC_W=7 and ROM_LAT=1. Instance B has PC_W=4, ROM_LAT=3 and RESET_VEC=E.
// Each instance has its own ROM model. The ROM returns data ROM_LAT cycles after the address.
module tb_ctrl_seq_v2;

  logic Clk;
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errs   = 0;
  int checks = 0;

  // ---------------- instance A ----------------
  logic        a_rst, a_zero, a_dwr, a_rfs, a_wen, a_ill;
  logic [6:0]  a_addr, a_pc;
  logic [15:0] a_q, a_ir;
  logic [7:0]  a_daddr;
  logic [3:0]  a_wa, a_ra, a_rb, a_st, a_nst;
  logic [2:0]  a_alu;
  logic [15:0] rom_a [0:127];
  assign a_q = rom_a[a_addr];

  ctrl_seq_v2 #(.PC_W(7), .ROM_LAT(1), .RESET_VEC(0)) u_a (
    .Clk(Clk), .Reset(a_rst), .rom_addr(a_addr), .rom_q(a_q), .alu_zero(a_zero),
    .PC_Out(a_pc), .IR_Out(a_ir), .D_Addr(a_daddr), .D_Wr(a_dwr), .RF_s(a_rfs),
    .RF_W_Addr(a_wa), .RF_Ra_Addr(a_ra), .RF_Rb_Addr(a_rb), .RF_W_en(a_wen),
    .ALU_s0(a_alu), .outState(a_st), .nextState(a_nst), .illegal(a_ill)
  );

  // ---------------- instance B ----------------
  logic        b_rst, b_dwr, b_rfs, b_wen, b_ill;
  logic [3:0]  b_addr, b_pc, b_d1, b_d2;
  logic [15:0] b_q, b_ir;
  logic [7:0]  b_daddr;
  logic [3:0]  b_wa, b_ra, b_rb, b_st, b_nst;
  logic [2:0]  b_alu;
  logic [15:0] rom_b [0:15];
  always @(posedge Clk) begin
    b_d1 <= b_addr;
    b_d2 <= b_d1;
  end
  assign b_q = rom_b[b_d2];

  ctrl_seq_v2 #(.PC_W(4), .ROM_LAT(3), .RESET_VEC(14)) u_b (
    .Clk(Clk), .Reset(b_rst), .rom_addr(b_addr), .rom_q(b_q), .alu_zero(1'b0),
    .PC_Out(b_pc), .IR_Out(b_ir), .D_Addr(b_daddr), .D_Wr(b_dwr), .RF_s(b_rfs),
    .RF_W_Addr(b_wa), .RF_Ra_Addr(b_ra), .RF_Rb_Addr(b_rb), .RF_W_en(b_wen),
    .ALU_s0(b_alu), .outState(b_st), .nextState(b_nst), .illegal(b_ill)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits, sampling on negedges, until the selected instance reaches state code.
  task automatic wait_st(input bit inst_b, input logic [3:0] code, input int budget,
                         input string tag);
    logic [3:0] s;
    s = 4'hX;
    for (int n = 0; n < budget; n++) begin
      @(negedge Clk);
      s = inst_b ? b_st : a_st;
      if (s == code) break;
    end
    check(tag, 32'(s), 32'(code));
  endtask

  logic bad;

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; a_zero = 1'b0;
    for (int i = 0; i < 128; i++) rom_a[i] = 16'h0000;
    for (int i = 0; i < 16; i++)  rom_b[i] = 16'h0000;
    rom_a[0]     = 16'h3ABC;  // ADD
    rom_a[1]     = 16'h2BC5;  // LOAD
    rom_a[2]     = 16'h1DE7;  // STORE
    rom_a[3]     = 16'h4123;  // SUB
    rom_a[4]     = 16'h6010;  // JMP 0x10
    rom_a[7'h10] = 16'h5000;  // HALT
    rom_b[14]    = 16'h0ABC;  // NOOP
    rom_b[15]    = 16'h0000;  // NOOP, PC wraps after this fetch
    rom_b[0]     = 16'hF123;  // illegal
    rom_b[1]     = 16'h0000;
    rom_b[2]     = 16'h5000;  // HALT
    #2;
    a_rst = 1'b0; b_rst = 1'b0;
    #18;
    check("rst_state", 32'(a_st), 32'h0);
    check("rst_pc", 32'(a_pc), 32'h0);
    check("rst_ir", 32'(a_ir), 32'h0);
    check("rst_ctrl", 32'({a_dwr, a_wen, a_rfs, a_ill}), 32'h0);
    check("rst_pc_b", 32'(b_pc), 32'hE);
    #11;
    a_rst = 1'b1;

    // ADD
    wait_st(0, 4'h7, 20, "a_add");
    check("add_nst", 32'(a_nst), 32'h1);
    check("add_regs", 32'({a_ra, a_rb, a_wa}), 32'hABC);
    check("add_alu_wen", 32'({a_alu, a_wen, a_dwr}), 32'b001_1_0);
    check("add_pc", 32'(a_pc), 32'h1);
    // LOAD
    wait_st(0, 4'h4, 10, "a_loada");
    check("loada_nst", 32'(a_nst), 32'h5);
    check("loada_out", 32'({a_daddr, a_wa, a_rfs, a_wen}), {20'h0, 8'hBC, 4'h5, 2'b10});
    @(negedge Clk);
    check("loadb_st", 32'({a_st, a_nst}), 32'h51);
    check("loadb_out", 32'({a_daddr, a_wa, a_rfs, a_wen}), {20'h0, 8'hBC, 4'h5, 2'b11});
    // STORE
    wait_st(0, 4'h6, 10, "a_store");
    check("store_out", 32'({a_daddr, a_ra, a_dwr, a_wen}), {20'h0, 8'hDE, 4'h7, 2'b10});
    // SUB
    wait_st(0, 4'h9, 10, "a_sub");
    check("sub_out", 32'({a_ra, a_rb, a_wa, a_alu, a_wen}), {15'h0, 12'h123, 3'b010, 1'b1});
    // JMP
    wait_st(0, 4'hA, 10, "a_jmp");
    check("jmp_pc_inc", 32'(a_pc), 32'h5);
    @(negedge Clk);
    check("jmp_fetch", 32'({a_st, a_pc, a_addr}), {17'h0, 4'h1, 7'h10, 7'h10});
    // HALT
    wait_st(0, 4'h8, 10, "a_halt");
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (a_st != 4'h8 || a_nst != 4'h8 || a_dwr || a_wen) bad = 1'b1;
    end
    check("halt_hold", 32'(bad), 32'h0);
    check("halt_pc", 32'(a_pc), 32'h11);

    // Opcode 7
    a_rst = 1'b0;
    rom_a[0] = 16'h7320;
    @(negedge Clk);
    check("rst2_state", 32'({a_st, a_pc}), 32'h0);
    a_rst = 1'b1;
`ifdef CTRL_JZ_EN
    a_zero = 1'b1;
    wait_st(0, 4'hB, 10, "jz_state");
    check("jz_out", 32'({a_ra, a_alu, a_nst}), {21'h0, 4'h3, 3'b000, 4'h1});
    wait_st(0, 4'h1, 4, "jz_taken_fetch");
    check("jz_taken_pc", 32'(a_pc), 32'h20);
    a_rst = 1'b0;
    @(negedge Clk);
    a_rst = 1'b1;
    a_zero = 1'b0;
    wait_st(0, 4'hB, 10, "jz_state2");
    wait_st(0, 4'h1, 4, "jz_nt_fetch");
    check("jz_nt_pc", 32'(a_pc), 32'h1);
`else
    wait_st(0, 4'h2, 10, "op7_decode");
    check("op7_ill_before", 32'(a_ill), 32'h0);
    @(negedge Clk);
    check("op7_noop", 32'(a_st), 32'h3);
    check("op7_ill", 32'(a_ill), 32'h1);
    check("op7_pc", 32'(a_pc), 32'h1);
`endif

    // Reset during LOAD
    a_rst = 1'b0;
    rom_a[0] = 16'h2BC5;
    @(negedge Clk);
    check("rst3_ill", 32'(a_ill), 32'h0);
    a_rst = 1'b1;
    wait_st(0, 4'h4, 10, "abort_loada");
    #2;
    a_rst = 1'b0;
    #1;
    check("abort_async", 32'(a_st), 32'h0);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (a_wen || a_dwr || a_st != 4'h0) bad = 1'b1;
    end
    check("abort_no_leak", 32'(bad), 32'h0);

    // Instance B: ROM_LAT=3, PC_W=4
    @(negedge Clk);
    b_rst = 1'b1;
    wait_st(1, 4'h1, 4, "b_fetch1");
    check("b_f1", 32'({b_addr, b_ir}), {12'h0, 4'hE, 16'h0});
    @(negedge Clk);
    check("b_f2", 32'({b_st, b_addr, b_ir}), {8'h0, 4'h1, 4'hE, 16'h0});
    @(negedge Clk);
    check("b_f3", 32'({b_st, b_addr, b_ir}), {8'h0, 4'h1, 4'hE, 16'h0});
    @(negedge Clk);
    check("b_decode", 32'({b_st, b_pc, b_ir}), {8'h0, 4'h2, 4'hF, 16'h0ABC});
    wait_st(1, 4'h2, 10, "b_decode_f");
    check("b_wrap_pc", 32'(b_pc), 32'h0);
    check("b_ill_pre", 32'(b_ill), 32'h0);
    wait_st(1, 4'h2, 10, "b_decode_bad");
    check("b_ir_bad", 32'(b_ir), 32'hF123);
    @(negedge Clk);
    check("b_bad_noop", 32'({b_st, b_ill}), {27'h0, 4'h3, 1'b1});
    wait_st(1, 4'h8, 20, "b_halt");
    check("b_ill_sticky", 32'({b_ill, b_ir}), {15'h0, 1'b1, 16'h5000});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
